cpu_clock_generator: RTL and testbench

- Generates the 8088 CPU clock timebase from the system clock: `cpu_clock`, one-cycle posedge/negedge strobes, and `peripheral_clock`.
- Performs 8284-style two-stage READY synchronisation and CPU reset conditioning.
- Sits directly upstream of the bus arbiter, whose pulse shaping is gated by `cpu_clock_posedge` / `cpu_clock_negedge`.
- All outputs are registered or decoded from registers in the `clock` domain; nothing is generated as a real clock net.

---
 rtl/kfpcjr_clock_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/cpu_clock_generator.sv | 169 ++++++++++++++++
 tb/tb_cpu_clock_generator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kfpcjr_clock_pkg.sv
// Shared constants for the PCjr-style CPU clock generator.
package kfpcjr_clock_pkg;

   // Default 8088 timebase: 3 system clocks per CPU clock, 1 of them high.
   localparam int CPU_CLOCK_DIV_DEFAULT  = 3;
   localparam int CPU_CLOCK_HIGH_DEFAULT = 1;
   // CPU clock periods RESET stays high after power-good is seen.
   localparam int CPU_RESET_HOLD_DEFAULT = 4;

   // Width of the phase counter for a given divider, never narrower than 1.
   function automatic int phase_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;
   logic stable;

   // Shift the async input through two flops; both settle to RESET_VALUE on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta   <= RESET_VALUE;
         stable <= RESET_VALUE;
      end else begin
         meta   <= d;
         stable <= meta;
      end
   end

   assign q = stable;

endmodule

// File: rtl/cpu_clock_generator.sv
// 8088 CPU clock timebase: phase counter, clock level and edge strobes,
// peripheral clock, 8284-style READY synchronisation and RESET conditioning.
module cpu_clock_generator
   import kfpcjr_clock_pkg::*;
#(
   parameter int CLOCK_DIV   = CPU_CLOCK_DIV_DEFAULT,
   parameter int HIGH_CYCLES = CPU_CLOCK_HIGH_DEFAULT,
   parameter int RESET_HOLD  = CPU_RESET_HOLD_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic res_n,
   input  logic rdy,
   input  logic aen_n,
   output logic cpu_clock,
   output logic cpu_clock_posedge,
   output logic cpu_clock_negedge,
   output logic peripheral_clock,
   output logic ready,
   output logic cpu_reset
);

   localparam int PHASE_W = phase_width(CLOCK_DIV);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLOCK_DIV - 1);
   localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(HIGH_CYCLES);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
   localparam logic [3:0]         HOLD_TARGET = 4'(RESET_HOLD);

   // Reject parameter sets outside the supported range at elaboration.
   if (CLOCK_DIV < 3 || CLOCK_DIV > 15) begin : g_bad_div
      $error("cpu_clock_generator: CLOCK_DIV must be 3..15");
   end
   if (HIGH_CYCLES < 1 || HIGH_CYCLES > CLOCK_DIV - 1) begin : g_bad_high
      $error("cpu_clock_generator: HIGH_CYCLES must be 1..CLOCK_DIV-1");
   end
   if (RESET_HOLD < 1 || RESET_HOLD > 15) begin : g_bad_hold
      $error("cpu_clock_generator: RESET_HOLD must be 1..15");
   end

   logic [PHASE_W-1:0] phase;
   logic               running;
   logic               posedge_strobe;
   logic               negedge_strobe;
   logic               pclk;

   logic               rdy_gated;
   logic               sync_rdy;
   logic               ready_p1;
   logic               ready_p2;

   logic               sync_res_n;
   logic [3:0]         hold_cnt;
   logic [3:0]         hold_next;
   logic               cpu_reset_r;

   // ---------------------------------------------------------------------
   // Phase counter. Reset parks it on the last phase so the first count
   // after reset lands on phase 0 and produces the first posedge strobe.
   // `running` suppresses strobes in the cycle right after reset.
   // ---------------------------------------------------------------------

   // Advance the phase 0..CLOCK_DIV-1 and note that reset has been left.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase   <= PHASE_LAST;
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         if (phase == PHASE_LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PHASE_ONE;
         end
      end
   end

   // Level and strobes are pure decodes of the registered phase, so each
   // strobe lines up with the first system cycle of the new clock level.
   assign cpu_clock      = (phase < PHASE_HIGH);
   assign posedge_strobe = running && (phase == '0);
   assign negedge_strobe = running && (phase == PHASE_HIGH);

   assign cpu_clock_posedge = posedge_strobe;
   assign cpu_clock_negedge = negedge_strobe;

   // ---------------------------------------------------------------------
   // Peripheral clock: CPU clock divided by two.
   // ---------------------------------------------------------------------

   // Toggle at the edge that closes every posedge-strobe cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         pclk <= 1'b0;
      end else if (posedge_strobe) begin
         pclk <= ~pclk;
      end
   end

   assign peripheral_clock = pclk;

   // ---------------------------------------------------------------------
   // READY path: async RDY qualified by AEN, synchronised, then retimed
   // onto CPU clock edges in two stages like the 8284.
   // ---------------------------------------------------------------------

   assign rdy_gated = rdy & ~aen_n;

   sync_2ff #(
      .RESET_VALUE (1'b0)
   ) u_sync_rdy (
      .clock (clock),
      .reset (reset),
      .d     (rdy_gated),
      .q     (sync_rdy)
   );

   // Stage 1 samples on the CPU rising edge, stage 2 on the falling edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         ready_p1 <= 1'b0;
         ready_p2 <= 1'b0;
      end else begin
         if (posedge_strobe) begin
            ready_p1 <= sync_rdy;
         end
         if (negedge_strobe) begin
            ready_p2 <= ready_p1;
         end
      end
   end

   assign ready = ready_p2;

   // ---------------------------------------------------------------------
   // CPU RESET path: power-good is synchronised, then RESET is held for
   // RESET_HOLD CPU clocks, counted on falling-edge strobes.
   // ---------------------------------------------------------------------

   sync_2ff #(
      .RESET_VALUE (1'b0)
   ) u_sync_res_n (
      .clock (clock),
      .reset (reset),
      .d     (res_n),
      .q     (sync_res_n)
   );

   assign hold_next = hold_cnt + 4'd1;

   // Any synchronised low clears the count, so even a glitch that misses a
   // negedge strobe still re-asserts RESET on the next counted strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_cnt    <= 4'd0;
         cpu_reset_r <= 1'b1;
      end else if (!sync_res_n) begin
         hold_cnt <= 4'd0;
         if (negedge_strobe) begin
            cpu_reset_r <= 1'b1;
         end
      end else if (negedge_strobe && (hold_cnt != HOLD_TARGET)) begin
         hold_cnt    <= hold_next;
         cpu_reset_r <= (hold_next != HOLD_TARGET);
      end
   end

   assign cpu_reset = cpu_reset_r;

endmodule

// File: tb/tb_cpu_clock_generator.sv
// Directed bench for cpu_clock_generator: default 3-clock timebase plus a
// 5-clock/2-high instance, RESET hold, READY retiming and mid-run reset.
module tb_cpu_clock_generator;

   logic clock;
   logic reset;
   logic res_n;
   logic rdy;
   logic aen_n;

   logic cpu_clock;
   logic cpu_clock_posedge;
   logic cpu_clock_negedge;
   logic peripheral_clock;
   logic ready;
   logic cpu_reset;

   logic cpu_clock5;
   logic cpu_clock_posedge5;
   logic cpu_clock_negedge5;
   logic peripheral_clock5;
   logic ready5;
   logic cpu_reset5;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Expected patterns, index = cycle number after reset release.
   bit exp3_clk [3]  = '{1, 0, 0};
   bit exp3_pos [3]  = '{1, 0, 0};
   bit exp3_neg [3]  = '{0, 1, 0};
   bit exp5_clk [5]  = '{1, 1, 0, 0, 0};
   bit exp5_pos [5]  = '{1, 0, 0, 0, 0};
   bit exp5_neg [5]  = '{0, 0, 1, 0, 0};
   bit exp3_pclk [15] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
   bit exp5_pclk [15] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};

   cpu_clock_generator dut (
      .clock             (clock),
      .reset             (reset),
      .res_n             (res_n),
      .rdy               (rdy),
      .aen_n             (aen_n),
      .cpu_clock         (cpu_clock),
      .cpu_clock_posedge (cpu_clock_posedge),
      .cpu_clock_negedge (cpu_clock_negedge),
      .peripheral_clock  (peripheral_clock),
      .ready             (ready),
      .cpu_reset         (cpu_reset)
   );

   cpu_clock_generator #(
      .CLOCK_DIV   (5),
      .HIGH_CYCLES (2),
      .RESET_HOLD  (4)
   ) dut5 (
      .clock             (clock),
      .reset             (reset),
      .res_n             (res_n),
      .rdy               (rdy),
      .aen_n             (aen_n),
      .cpu_clock         (cpu_clock5),
      .cpu_clock_posedge (cpu_clock_posedge5),
      .cpu_clock_negedge (cpu_clock_negedge5),
      .peripheral_clock  (peripheral_clock5),
      .ready             (ready5),
      .cpu_reset         (cpu_reset5)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle index: 0 is the first cycle with reset low.
   always @(posedge clock) begin
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
   end

   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      while (cyc != target && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (cyc != target) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wait_cyc got cyc=%0d want cyc=%0d", cyc, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      res_n = 1'b0;
      rdy   = 1'b0;
      aen_n = 1'b0;
      repeat (3) @(negedge clock);
      tests_run++; if (cpu_clock !== 1'b0) begin tests_failed++; $display("FAIL rst_cpu_clock got=%b exp=0", cpu_clock); end
      tests_run++; if (cpu_clock_posedge !== 1'b0) begin tests_failed++; $display("FAIL rst_posedge got=%b exp=0", cpu_clock_posedge); end
      tests_run++; if (cpu_clock_negedge !== 1'b0) begin tests_failed++; $display("FAIL rst_negedge got=%b exp=0", cpu_clock_negedge); end
      tests_run++; if (peripheral_clock !== 1'b0) begin tests_failed++; $display("FAIL rst_pclk got=%b exp=0", peripheral_clock); end
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready got=%b exp=0", ready); end
      tests_run++; if (cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
      tests_run++; if (cpu_clock5 !== 1'b0) begin tests_failed++; $display("FAIL rst5_cpu_clock got=%b exp=0", cpu_clock5); end
      tests_run++; if (cpu_clock_posedge5 !== 1'b0) begin tests_failed++; $display("FAIL rst5_posedge got=%b exp=0", cpu_clock_posedge5); end
      tests_run++; if (cpu_clock_negedge5 !== 1'b0) begin tests_failed++; $display("FAIL rst5_negedge got=%b exp=0", cpu_clock_negedge5); end
      tests_run++; if (peripheral_clock5 !== 1'b0) begin tests_failed++; $display("FAIL rst5_pclk got=%b exp=0", peripheral_clock5); end
      tests_run++; if (ready5 !== 1'b0) begin tests_failed++; $display("FAIL rst5_ready got=%b exp=0", ready5); end
      tests_run++; if (cpu_reset5 !== 1'b1) begin tests_failed++; $display("FAIL rst5_cpu_reset got=%b exp=1", cpu_reset5); end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      bit e_clk, e_pos, e_neg;
      for (int k = 0; k < 15; k++) begin
         e_clk = (k == 0) ? 1'b0 : exp3_clk[(k - 1) % 3];
         e_pos = (k == 0) ? 1'b0 : exp3_pos[(k - 1) % 3];
         e_neg = (k == 0) ? 1'b0 : exp3_neg[(k - 1) % 3];
         tests_run++; if (cpu_clock !== e_clk) begin tests_failed++; $display("FAIL run3_clk cyc=%0d got=%b exp=%b", k, cpu_clock, e_clk); end
         tests_run++; if (cpu_clock_posedge !== e_pos) begin tests_failed++; $display("FAIL run3_pos cyc=%0d got=%b exp=%b", k, cpu_clock_posedge, e_pos); end
         tests_run++; if (cpu_clock_negedge !== e_neg) begin tests_failed++; $display("FAIL run3_neg cyc=%0d got=%b exp=%b", k, cpu_clock_negedge, e_neg); end
         tests_run++; if (peripheral_clock !== exp3_pclk[k]) begin tests_failed++; $display("FAIL run3_pclk cyc=%0d got=%b exp=%b", k, peripheral_clock, exp3_pclk[k]); end
         e_clk = (k == 0) ? 1'b0 : exp5_clk[(k - 1) % 5];
         e_pos = (k == 0) ? 1'b0 : exp5_pos[(k - 1) % 5];
         e_neg = (k == 0) ? 1'b0 : exp5_neg[(k - 1) % 5];
         tests_run++; if (cpu_clock5 !== e_clk) begin tests_failed++; $display("FAIL run5_clk cyc=%0d got=%b exp=%b", k, cpu_clock5, e_clk); end
         tests_run++; if (cpu_clock_posedge5 !== e_pos) begin tests_failed++; $display("FAIL run5_pos cyc=%0d got=%b exp=%b", k, cpu_clock_posedge5, e_pos); end
         tests_run++; if (cpu_clock_negedge5 !== e_neg) begin tests_failed++; $display("FAIL run5_neg cyc=%0d got=%b exp=%b", k, cpu_clock_negedge5, e_neg); end
         tests_run++; if (peripheral_clock5 !== exp5_pclk[k]) begin tests_failed++; $display("FAIL run5_pclk cyc=%0d got=%b exp=%b", k, peripheral_clock5, exp5_pclk[k]); end
         @(negedge clock);
      end
   endtask

   task automatic test_cpu_reset();
      bit e;
      // Power-good rises in cycle 20; synchronised from 22; strobes 23,26,29,32.
      wait_cyc(20);
      res_n = 1'b1;
      for (int k = 21; k <= 36; k++) begin
         @(negedge clock);
         e = (cyc <= 32);
         tests_run++; if (cpu_reset !== e) begin tests_failed++; $display("FAIL hold_release cyc=%0d got=%b exp=%b", cyc, cpu_reset, e); end
      end
      // 3-cycle low pulse in cycles 40..42: re-asserts at end of 44, counts 47..56.
      wait_cyc(40);
      res_n = 1'b0;
      for (int k = 41; k <= 60; k++) begin
         @(negedge clock);
         e = (cyc >= 45 && cyc <= 56);
         tests_run++; if (cpu_reset !== e) begin tests_failed++; $display("FAIL hold_glitch cyc=%0d got=%b exp=%b", cyc, cpu_reset, e); end
         if (cyc == 43) res_n = 1'b1;
      end
   endtask

   task automatic test_ready();
      bit e;
      // RDY rises in low phase cycle 63; posedge strobe 67, negedge strobe 68.
      wait_cyc(63);
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL ready_pre got=%b exp=0", ready); end
      rdy = 1'b1;
      for (int k = 64; k <= 74; k++) begin
         @(negedge clock);
         e = (cyc >= 69);
         tests_run++; if (ready !== e) begin tests_failed++; $display("FAIL ready_rise cyc=%0d got=%b exp=%b", cyc, ready, e); end
      end
   endtask

   task automatic test_aen_mask();
      bit e;
      // AEN high from cycle 75 masks RDY; ready falls at end of strobe 80.
      wait_cyc(75);
      aen_n = 1'b1;
      for (int k = 76; k <= 95; k++) begin
         @(negedge clock);
         e = (cyc <= 80);
         tests_run++; if (ready !== e) begin tests_failed++; $display("FAIL aen_mask cyc=%0d got=%b exp=%b", cyc, ready, e); end
      end
      // Unmask at 96; ready returns at end of negedge strobe 101.
      wait_cyc(96);
      aen_n = 1'b0;
      for (int k = 97; k <= 102; k++) begin
         @(negedge clock);
         e = (cyc >= 102);
         tests_run++; if (ready !== e) begin tests_failed++; $display("FAIL aen_unmask cyc=%0d got=%b exp=%b", cyc, ready, e); end
      end
   endtask

   task automatic test_reset_mid();
      // res_n pulse 103..105 leaves hold_cnt = 2 in cycle 116 (phase 1).
      wait_cyc(103);
      res_n = 1'b0;
      wait_cyc(106);
      res_n = 1'b1;
      wait_cyc(116);
      tests_run++; if (cpu_clock_negedge !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_neg got=%b exp=1", cpu_clock_negedge); end
      tests_run++; if (peripheral_clock !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_pclk got=%b exp=1", peripheral_clock); end
      tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_ready got=%b exp=1", ready); end
      tests_run++; if (cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_cpu_reset got=%b exp=1", cpu_reset); end
      tests_run++; if (cpu_clock_posedge5 !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_pos5 got=%b exp=1", cpu_clock_posedge5); end
      reset = 1'b1;
      @(negedge clock);
      tests_run++; if (cpu_clock !== 1'b0) begin tests_failed++; $display("FAIL mid_cpu_clock got=%b exp=0", cpu_clock); end
      tests_run++; if (cpu_clock_posedge !== 1'b0) begin tests_failed++; $display("FAIL mid_posedge got=%b exp=0", cpu_clock_posedge); end
      tests_run++; if (cpu_clock_negedge !== 1'b0) begin tests_failed++; $display("FAIL mid_negedge got=%b exp=0", cpu_clock_negedge); end
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready got=%b exp=0", ready); end
      tests_run++; if (cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL mid_cpu_reset got=%b exp=1", cpu_reset); end
      tests_run++; if (peripheral_clock !== 1'b0) begin tests_failed++; $display("FAIL mid_pclk got=%b exp=0", peripheral_clock); end
      tests_run++; if (cpu_clock_posedge5 !== 1'b0) begin tests_failed++; $display("FAIL mid_pos5 got=%b exp=0", cpu_clock_posedge5); end
      reset = 1'b0;
      @(negedge clock);
      tests_run++; if (cpu_clock !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_clk got=%b exp=1", cpu_clock); end
      tests_run++; if (cpu_clock_posedge !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_pos got=%b exp=1", cpu_clock_posedge); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_cpu_reset();
      test_ready();
      test_aen_mask();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
